// File: rtl/system_types_pkg.sv
// rtl/system_types_pkg.sv - shared widths, address/data types and miss-return FSM states
package system_types_pkg;

    localparam int L1_BLOCK_ADDR_WIDTH  = 29;
    localparam int COH_BLOCK_ADDR_WIDTH = 28;
    localparam int L1_BLOCK_SIZE_BITS   = 256;
    localparam int COH_BLOCK_SIZE_BITS  = 512;

    typedef logic [L1_BLOCK_ADDR_WIDTH-1:0]  l1_PA29_t;
    typedef logic [COH_BLOCK_ADDR_WIDTH-1:0] coh_PA28_t;
    typedef logic [L1_BLOCK_SIZE_BITS-1:0]   data256_t;
    typedef logic [COH_BLOCK_SIZE_BITS-1:0]  data512_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COH_REQ   = 2'd1,
        WAIT_RESP = 2'd2,
        RESP      = 2'd3
    } l1_miss_return_state_t;

    // An L1 block is one half of a coherence block; the low address bit picks the half.
    function automatic coh_PA28_t to_PA28(input l1_PA29_t pa29);
        return pa29[L1_BLOCK_ADDR_WIDTH-1:1];
    endfunction

    function automatic data256_t select_half(input data512_t data, input logic half);
        return half ? data[COH_BLOCK_SIZE_BITS-1:L1_BLOCK_SIZE_BITS]
                    : data[L1_BLOCK_SIZE_BITS-1:0];
    endfunction

endpackage

// File: rtl/l1_miss_return_unit_coh_block_buffer.sv
// rtl/l1_miss_return_unit_coh_block_buffer.sv - one-entry 512b coherence block buffer with invalidate and half-select read
module coh_block_buffer
    import system_types_pkg::*;
(
    input  logic                            CLK,
    input  logic                            nRST,
    input  logic                            load_en,
    input  logic [COH_BLOCK_ADDR_WIDTH-1:0] load_PA28,
    input  logic [COH_BLOCK_SIZE_BITS-1:0]  load_data512,
    input  logic                            inv_valid,
    input  logic [COH_BLOCK_ADDR_WIDTH-1:0] inv_PA28,
    input  logic [COH_BLOCK_ADDR_WIDTH-1:0] lookup_PA28,
    input  logic                            lookup_half,
    output logic                            hit,
    output logic [L1_BLOCK_SIZE_BITS-1:0]   rd_data256
);

    logic      buffer_valid;
    coh_PA28_t buffer_PA28;
    data512_t  buffer_data512;

    // A load replaces the entry outright; otherwise a matching invalidation drops it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            buffer_valid   <= 1'b0;
            buffer_PA28    <= '0;
            buffer_data512 <= '0;
        end else if (load_en) begin
            buffer_valid   <= 1'b1;
            buffer_PA28    <= load_PA28;
            buffer_data512 <= load_data512;
        end else if (inv_valid && (inv_PA28 == buffer_PA28)) begin
            buffer_valid   <= 1'b0;
        end
    end

    // An invalidation arriving in the lookup cycle beats the hit, so stale data is never returned.
    always_comb begin
        hit        = buffer_valid && (buffer_PA28 == lookup_PA28)
                     && !(inv_valid && (inv_PA28 == lookup_PA28));
        rd_data256 = select_half(buffer_data512, lookup_half);
    end

endmodule

// File: rtl/l1_miss_return_unit.sv
// rtl/l1_miss_return_unit.sv - converts L1 PA29 misses into PA28 coherence requests and returns the requested half
module l1_miss_return_unit
    import system_types_pkg::*;
#(
    parameter bit ENABLE_BLOCK_BUFFER = 1'b1
) (
    input  logic                            CLK,
    input  logic                            nRST,
    input  logic                            l1_req_valid,
    output logic                            l1_req_ready,
    input  logic [L1_BLOCK_ADDR_WIDTH-1:0]  l1_req_PA29,
    output logic                            l1_resp_valid,
    input  logic                            l1_resp_ready,
    output logic [L1_BLOCK_ADDR_WIDTH-1:0]  l1_resp_PA29,
    output logic [L1_BLOCK_SIZE_BITS-1:0]   l1_resp_data256,
    output logic                            coh_req_valid,
    input  logic                            coh_req_ready,
    output logic [COH_BLOCK_ADDR_WIDTH-1:0] coh_req_PA28,
    input  logic                            coh_resp_valid,
    input  logic [COH_BLOCK_ADDR_WIDTH-1:0] coh_resp_PA28,
    input  logic [COH_BLOCK_SIZE_BITS-1:0]  coh_resp_data512,
    input  logic                            inv_valid,
    input  logic [COH_BLOCK_ADDR_WIDTH-1:0] inv_PA28
);

    l1_miss_return_state_t state;
    l1_PA29_t              req_PA29;
    logic                  poison;

    logic     buf_hit_raw;
    data256_t buf_rd_data256;
    logic     buf_hit;
    logic     resp_match;
    logic     inv_in_flight;
    logic     buf_load_en;

    // Lookup runs on the incoming request address so a hit can be decided in the IDLE cycle.
    coh_block_buffer u_coh_block_buffer (
        .CLK          (CLK),
        .nRST         (nRST),
        .load_en      (buf_load_en),
        .load_PA28    (coh_resp_PA28),
        .load_data512 (coh_resp_data512),
        .inv_valid    (inv_valid),
        .inv_PA28     (inv_PA28),
        .lookup_PA28  (to_PA28(l1_req_PA29)),
        .lookup_half  (l1_req_PA29[0]),
        .hit          (buf_hit_raw),
        .rd_data256   (buf_rd_data256)
    );

    // coh_req_PA28 doubles as the in-flight block address once a miss is taken.
    always_comb begin
        buf_hit       = ENABLE_BLOCK_BUFFER && buf_hit_raw;
        resp_match    = coh_resp_valid && (coh_resp_PA28 == coh_req_PA28);
        inv_in_flight = inv_valid && (inv_PA28 == coh_req_PA28);
        buf_load_en   = ENABLE_BLOCK_BUFFER && (state == WAIT_RESP) && resp_match
                        && !poison && !inv_in_flight;
    end

    // Request/response sequencing with all handshake outputs registered.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state           <= IDLE;
            req_PA29        <= '0;
            poison          <= 1'b0;
            l1_req_ready    <= 1'b1;
            l1_resp_valid   <= 1'b0;
            l1_resp_PA29    <= '0;
            l1_resp_data256 <= '0;
            coh_req_valid   <= 1'b0;
            coh_req_PA28    <= '0;
        end else begin
            if (((state == COH_REQ) || (state == WAIT_RESP)) && inv_in_flight) begin
                poison <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (l1_req_valid) begin
                        req_PA29     <= l1_req_PA29;
                        coh_req_PA28 <= to_PA28(l1_req_PA29);
                        l1_req_ready <= 1'b0;
                        if (buf_hit) begin
                            l1_resp_valid   <= 1'b1;
                            l1_resp_PA29    <= l1_req_PA29;
                            l1_resp_data256 <= buf_rd_data256;
                            state           <= RESP;
                        end else begin
                            coh_req_valid <= 1'b1;
                            state         <= COH_REQ;
                        end
                    end
                end
                COH_REQ: begin
                    if (coh_req_ready) begin
                        coh_req_valid <= 1'b0;
                        state         <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (resp_match) begin
                        l1_resp_valid   <= 1'b1;
                        l1_resp_PA29    <= req_PA29;
                        l1_resp_data256 <= select_half(coh_resp_data512, req_PA29[0]);
                        state           <= RESP;
                    end
                end
                RESP: begin
                    if (l1_resp_ready) begin
                        l1_resp_valid <= 1'b0;
                        l1_req_ready  <= 1'b1;
                        poison        <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_miss_return_unit.sv
// tb/tb_l1_miss_return_unit.sv - directed self-checking bench for l1_miss_return_unit
module tb_l1_miss_return_unit;

    logic         CLK;
    logic         nRST;
    logic         l1_req_valid;
    logic         l1_req_ready;
    logic [28:0]  l1_req_PA29;
    logic         l1_resp_valid;
    logic         l1_resp_ready;
    logic [28:0]  l1_resp_PA29;
    logic [255:0] l1_resp_data256;
    logic         coh_req_valid;
    logic         coh_req_ready;
    logic [27:0]  coh_req_PA28;
    logic         coh_resp_valid;
    logic [27:0]  coh_resp_PA28;
    logic [511:0] coh_resp_data512;
    logic         inv_valid;
    logic [27:0]  inv_PA28;

    int checks;
    int failures;
    int coh_req_count;
    int l1_resp_count;

    logic [255:0] d_aa;
    logic [255:0] d_55;
    logic [255:0] d_hi2;
    logic [255:0] d_lo2;

    l1_miss_return_unit dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .l1_req_valid     (l1_req_valid),
        .l1_req_ready     (l1_req_ready),
        .l1_req_PA29      (l1_req_PA29),
        .l1_resp_valid    (l1_resp_valid),
        .l1_resp_ready    (l1_resp_ready),
        .l1_resp_PA29     (l1_resp_PA29),
        .l1_resp_data256  (l1_resp_data256),
        .coh_req_valid    (coh_req_valid),
        .coh_req_ready    (coh_req_ready),
        .coh_req_PA28     (coh_req_PA28),
        .coh_resp_valid   (coh_resp_valid),
        .coh_resp_PA28    (coh_resp_PA28),
        .coh_resp_data512 (coh_resp_data512),
        .inv_valid        (inv_valid),
        .inv_PA28         (inv_PA28)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (nRST && coh_req_valid && coh_req_ready) coh_req_count <= coh_req_count + 1;
        if (nRST && l1_resp_valid && l1_resp_ready) l1_resp_count <= l1_resp_count + 1;
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_req(input logic [28:0] pa);
        check("req_ready_idle", l1_req_ready, 1'b1);
        l1_req_valid = 1'b1;
        l1_req_PA29  = pa;
        step();
        l1_req_valid = 1'b0;
    endtask

    task automatic fabric_accept(input int stall, input logic [27:0] pa28);
        coh_req_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            check("coh_req_valid_stall", coh_req_valid, 1'b1);
            check("coh_req_PA28_stall", coh_req_PA28, pa28);
            step();
        end
        check("coh_req_valid", coh_req_valid, 1'b1);
        check("coh_req_PA28", coh_req_PA28, pa28);
        coh_req_ready = 1'b1;
        step();
        coh_req_ready = 1'b0;
        check("coh_req_valid_drop", coh_req_valid, 1'b0);
    endtask

    task automatic fabric_return(input logic [27:0] pa28, input logic [511:0] data, input logic with_inv);
        coh_resp_valid   = 1'b1;
        coh_resp_PA28    = pa28;
        coh_resp_data512 = data;
        inv_valid        = with_inv;
        inv_PA28         = pa28;
        step();
        coh_resp_valid   = 1'b0;
        inv_valid        = 1'b0;
    endtask

    task automatic l1_take(input int stall, input logic [28:0] pa, input logic [255:0] data);
        l1_resp_ready = 1'b0;
        for (int i = 0; i <= stall; i++) begin
            check("l1_resp_valid", l1_resp_valid, 1'b1);
            check("l1_resp_PA29", l1_resp_PA29, pa);
            check("l1_resp_data256", l1_resp_data256, data);
            check("req_ready_busy", l1_req_ready, 1'b0);
            if (i < stall) step();
        end
        l1_resp_ready = 1'b1;
        step();
        l1_resp_ready = 1'b0;
        check("l1_resp_valid_drop", l1_resp_valid, 1'b0);
        check("req_ready_back", l1_req_ready, 1'b1);
    endtask

    task automatic inv_pulse(input logic [27:0] pa28);
        inv_valid = 1'b1;
        inv_PA28  = pa28;
        step();
        inv_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, l1_req_ready, 1'b1);
        check({tag, "_resp_valid"}, l1_resp_valid, 1'b0);
        check({tag, "_resp_PA29"}, l1_resp_PA29, 29'd0);
        check({tag, "_resp_data"}, l1_resp_data256, 256'd0);
        check({tag, "_coh_valid"}, coh_req_valid, 1'b0);
        check({tag, "_coh_PA28"}, coh_req_PA28, 28'd0);
    endtask

    initial begin
        int c0;
        int r0;
        checks = 0;
        failures = 0;
        coh_req_count = 0;
        l1_resp_count = 0;
        d_aa  = {32{8'hAA}};
        d_55  = {32{8'h55}};
        d_hi2 = {16{16'h1234}};
        d_lo2 = {8{32'hCAFE_F00D}};
        nRST = 1'b0;
        l1_req_valid = 1'b0;
        l1_req_PA29 = '0;
        l1_resp_ready = 1'b0;
        coh_req_ready = 1'b0;
        coh_resp_valid = 1'b0;
        coh_resp_PA28 = '0;
        coh_resp_data512 = '0;
        inv_valid = 1'b0;
        inv_PA28 = '0;

        step();
        step();
        check_reset_outputs("rst");
        nRST = 1'b1;
        step();
        check_reset_outputs("post_rst");

        // Cold miss: upper half returned because PA29 bit0 is 1.
        send_req(29'h0A3);
        check("cold_req_ready", l1_req_ready, 1'b0);
        fabric_accept(0, 28'h051);
        fabric_return(28'h051, {d_aa, d_55}, 1'b0);
        l1_take(0, 29'h0A3, d_aa);

        // Sibling hit: no fabric request, response one cycle after handshake.
        c0 = coh_req_count;
        send_req(29'h0A2);
        check("hit_coh_valid", coh_req_valid, 1'b0);
        l1_take(0, 29'h0A2, d_55);
        check("hit_no_fabric", coh_req_count, c0);

        // Backpressure on both sides: exactly one request and one response.
        c0 = coh_req_count;
        r0 = l1_resp_count;
        send_req(29'h1F0);
        fabric_accept(5, 28'h0F8);
        fabric_return(28'h0F8, {d_hi2, d_lo2}, 1'b0);
        l1_take(4, 29'h1F0, d_lo2);
        check("bp_one_fabric_req", coh_req_count, c0 + 1);
        check("bp_one_l1_resp", l1_resp_count, r0 + 1);

        // Buffer was replaced by 0x0F8, so 0x0A3 misses again and reloads 0x051.
        send_req(29'h0A3);
        fabric_accept(0, 28'h051);
        fabric_return(28'h051, {d_aa, d_55}, 1'b0);
        l1_take(0, 29'h0A3, d_aa);

        // Invalidate the buffered block: sibling now misses.
        inv_pulse(28'h051);
        send_req(29'h0A2);
        fabric_accept(0, 28'h051);
        fabric_return(28'h051, {d_aa, d_55}, 1'b0);
        l1_take(0, 29'h0A2, d_55);

        // Invalidation in the same cycle as a would-be hit wins.
        inv_valid = 1'b1;
        inv_PA28  = 28'h051;
        send_req(29'h0A3);
        inv_valid = 1'b0;
        fabric_accept(0, 28'h051);
        fabric_return(28'h051, {d_aa, d_55}, 1'b0);
        l1_take(0, 29'h0A3, d_aa);

        // Poison during WAIT_RESP: data returned once, not buffered.
        inv_pulse(28'h051);
        r0 = l1_resp_count;
        send_req(29'h0A3);
        fabric_accept(0, 28'h051);
        inv_pulse(28'h051);
        check("poison_wait_no_resp", l1_resp_valid, 1'b0);
        fabric_return(28'h051, {d_aa, d_55}, 1'b0);
        l1_take(0, 29'h0A3, d_aa);
        check("poison_one_resp", l1_resp_count, r0 + 1);
        send_req(29'h0A2);
        check("poison_sibling_miss", coh_req_valid, 1'b1);
        fabric_accept(0, 28'h051);
        fabric_return(28'h051, {d_aa, d_55}, 1'b0);
        l1_take(0, 29'h0A2, d_55);

        // Invalidation in the same cycle as the data return: returned, not buffered.
        inv_pulse(28'h051);
        send_req(29'h0A3);
        fabric_accept(0, 28'h051);
        fabric_return(28'h051, {d_aa, d_55}, 1'b1);
        l1_take(0, 29'h0A3, d_aa);
        send_req(29'h0A2);
        check("inv_resp_sibling_miss", coh_req_valid, 1'b1);
        fabric_accept(0, 28'h051);
        fabric_return(28'h051, {d_aa, d_55}, 1'b0);
        l1_take(0, 29'h0A2, d_55);

        // Stray response is ignored, then reset mid-WAIT_RESP discards everything.
        send_req(29'h3C5);
        fabric_accept(0, 28'h1E2);
        fabric_return(28'h777, {d_55, d_aa}, 1'b0);
        check("stray_no_resp", l1_resp_valid, 1'b0);
        step();
        check("stray_still_waiting", l1_resp_valid, 1'b0);
        check("stray_no_new_req", coh_req_valid, 1'b0);
        nRST = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        step();
        nRST = 1'b1;
        step();
        send_req(29'h0A2);
        check("post_rst_miss", coh_req_valid, 1'b1);
        fabric_accept(0, 28'h051);
        fabric_return(28'h051, {d_hi2, d_lo2}, 1'b0);
        l1_take(0, 29'h0A2, d_lo2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
